platform_field: RTL and testbench



---
 rtl/platform_pkg.sv | 29 ++
 rtl/plat_lfsr.sv | 20 ++
 rtl/platform_field.sv | 202 ++++++++++++++++++++
 tb/tb_platform_field.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
// Shared constants, types and state encoding for the platform field.
// Imported by the platform store and its LFSR.
package platform_pkg;

    localparam int NUM_PLAT    = 16;
    localparam int PLAT_HALF_X = 16;
    localparam int PLAT_HALF_Y = 3;
    localparam int MAX_STEP    = 63;
    localparam int Y_BOTTOM    = 479;
    localparam int Y_SPAN      = 480;
    localparam int LOAD_Y0     = 465;
    localparam int LOAD_DY     = 30;
    localparam int X_BASE      = 48;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [8:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        SCROLL,
        DONE
    } pf_state_t;

endpackage

// File: rtl/plat_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to pick platform X positions.
// Reloads the seed on reset, so the sequence is repeatable from reset.
module plat_lfsr
    import platform_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [15:0] q
);

    // shift left, feedback is the parity of the tapped bits
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/platform_field.sv
// Platform store and scroller: lays out 16 platforms on load and shifts
// them down on scroll requests, recycling those that leave the bottom.
module platform_field
    import platform_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        loadplat,
    input  logic        refresh_en,
    input  logic [9:0]  plat_temp_Y,
    output logic [8:0]  platX,
    output logic [8:0]  platX1,
    output logic [8:0]  platX2,
    output logic [8:0]  platX3,
    output logic [8:0]  platX4,
    output logic [8:0]  platX5,
    output logic [8:0]  platX6,
    output logic [8:0]  platX7,
    output logic [8:0]  platX8,
    output logic [8:0]  platX9,
    output logic [8:0]  platX10,
    output logic [8:0]  platX11,
    output logic [8:0]  platX12,
    output logic [8:0]  platX13,
    output logic [8:0]  platX14,
    output logic [8:0]  platX15,
    output logic [8:0]  platY,
    output logic [8:0]  platY1,
    output logic [8:0]  platY2,
    output logic [8:0]  platY3,
    output logic [8:0]  platY4,
    output logic [8:0]  platY5,
    output logic [8:0]  platY6,
    output logic [8:0]  platY7,
    output logic [8:0]  platY8,
    output logic [8:0]  platY9,
    output logic [8:0]  platY10,
    output logic [8:0]  platY11,
    output logic [8:0]  platY12,
    output logic [8:0]  platY13,
    output logic [8:0]  platY14,
    output logic [8:0]  platY15,
    output logic [8:0]  plat_sizeX,
    output logic [8:0]  plat_sizeY,
    output logic        trigger,
    output logic        busy,
    output logic [15:0] scroll_total
);

    pf_state_t   state;
    pf_state_t   state_n;
    logic [3:0]  idx;
    logic [9:0]  mag;
    coord_t      px [NUM_PLAT];
    coord_t      py [NUM_PLAT];
    logic [15:0] lfsr_q;
    logic        unused_lfsr_msb;

    logic [9:0]  neg_y;
    logic [9:0]  mag_in;
    logic [9:0]  ny;
    logic        wrap;
    coord_t      cur_y;
    coord_t      new_x;
    coord_t      load_y;
    logic [16:0] tot_sum;

    plat_lfsr u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .q       (lfsr_q)
    );

    assign unused_lfsr_msb = lfsr_q[15];

    // next-state: loadplat preempts everything except an ongoing load
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (loadplat) state_n = LOAD;
            end
            LOAD: begin
                if (idx == 4'd15) state_n = READY;
            end
            READY: begin
                if (loadplat)                      state_n = LOAD;
                else if (refresh_en && frame_tick) state_n = SCROLL;
            end
            SCROLL: begin
                if (loadplat)          state_n = LOAD;
                else if (idx == 4'd15) state_n = DONE;
            end
            DONE: begin
                if (loadplat)         state_n = LOAD;
                else if (!refresh_en) state_n = READY;
            end
            default: state_n = IDLE;
        endcase
    end

    // datapath: shift magnitude, wrapped Y, fresh X and running total
    always_comb begin
        neg_y  = -plat_temp_Y;
        mag_in = '0;
        if (plat_temp_Y[9]) begin
            mag_in = (neg_y > 10'(MAX_STEP)) ? 10'(MAX_STEP) : neg_y;
        end
        cur_y   = py[idx];
        ny      = {1'b0, cur_y} + mag;
        wrap    = ny > 10'(Y_BOTTOM);
        new_x   = 9'(X_BASE) + {1'b0, lfsr_q[7:0]} + {2'b0, lfsr_q[14:8]};
        load_y  = 9'(LOAD_Y0 - LOAD_DY * int'(idx));
        tot_sum = {1'b0, scroll_total} + {7'b0, mag_in};
    end

    // state register, platform index and status flags
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            mag          <= '0;
            busy         <= 1'b0;
            trigger      <= 1'b0;
            scroll_total <= '0;
        end else begin
            state   <= state_n;
            busy    <= (state_n == LOAD) || (state_n == SCROLL);
            trigger <= (state == DONE) && !loadplat;
            if (state_n != state) begin
                idx <= '0;
            end else if (state == LOAD || state == SCROLL) begin
                idx <= idx + 4'd1;
            end
            if (state_n == LOAD && state != LOAD) begin
                scroll_total <= '0;
            end else if (state == READY && state_n == SCROLL) begin
                mag          <= mag_in;
                scroll_total <= tot_sum[16] ? 16'hFFFF : tot_sum[15:0];
            end
        end
    end

    // platform store: one entry written per LOAD or SCROLL cycle
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else if (state == LOAD) begin
            px[idx] <= new_x;
            py[idx] <= load_y;
        end else if (state == SCROLL && !loadplat) begin
            if (wrap) begin
                px[idx] <= new_x;
                py[idx] <= 9'(ny - 10'(Y_SPAN));
            end else begin
                py[idx] <= ny[8:0];
            end
        end
    end

    assign plat_sizeX = 9'(PLAT_HALF_X);
    assign plat_sizeY = 9'(PLAT_HALF_Y);

    assign platX   = px[0];
    assign platX1  = px[1];
    assign platX2  = px[2];
    assign platX3  = px[3];
    assign platX4  = px[4];
    assign platX5  = px[5];
    assign platX6  = px[6];
    assign platX7  = px[7];
    assign platX8  = px[8];
    assign platX9  = px[9];
    assign platX10 = px[10];
    assign platX11 = px[11];
    assign platX12 = px[12];
    assign platX13 = px[13];
    assign platX14 = px[14];
    assign platX15 = px[15];

    assign platY   = py[0];
    assign platY1  = py[1];
    assign platY2  = py[2];
    assign platY3  = py[3];
    assign platY4  = py[4];
    assign platY5  = py[5];
    assign platY6  = py[6];
    assign platY7  = py[7];
    assign platY8  = py[8];
    assign platY9  = py[9];
    assign platY10 = py[10];
    assign platY11 = py[11];
    assign platY12 = py[12];
    assign platY13 = py[13];
    assign platY14 = py[14];
    assign platY15 = py[15];

endmodule

// File: tb/tb_platform_field.sv
// Self-checking bench for platform_field: table vectors, hand sequences
// and random scrolls against a behavioural platform model.
module tb_platform_field;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        loadplat = 1'b0;
    logic        refresh_en = 1'b0;
    logic [9:0]  plat_temp_Y = '0;
    logic [8:0]  ox [16];
    logic [8:0]  oy [16];
    logic [8:0]  sx;
    logic [8:0]  sy;
    logic        trigger;
    logic        busy;
    logic [15:0] scroll_total;

    platform_field dut (
        .Clk(clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .loadplat(loadplat), .refresh_en(refresh_en),
        .plat_temp_Y(plat_temp_Y),
        .platX(ox[0]), .platX1(ox[1]), .platX2(ox[2]), .platX3(ox[3]),
        .platX4(ox[4]), .platX5(ox[5]), .platX6(ox[6]), .platX7(ox[7]),
        .platX8(ox[8]), .platX9(ox[9]), .platX10(ox[10]),
        .platX11(ox[11]), .platX12(ox[12]), .platX13(ox[13]),
        .platX14(ox[14]), .platX15(ox[15]),
        .platY(oy[0]), .platY1(oy[1]), .platY2(oy[2]), .platY3(oy[3]),
        .platY4(oy[4]), .platY5(oy[5]), .platY6(oy[6]), .platY7(oy[7]),
        .platY8(oy[8]), .platY9(oy[9]), .platY10(oy[10]),
        .platY11(oy[11]), .platY12(oy[12]), .platY13(oy[13]),
        .platY14(oy[14]), .platY15(oy[15]),
        .plat_sizeX(sx), .plat_sizeY(sy),
        .trigger(trigger), .busy(busy), .scroll_total(scroll_total)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [15:0] mlfsr = 16'hACE1;
    logic [15:0] hist [65536];
    int mx [16];
    int my [16];
    int mtot = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int fx(input logic [15:0] v);
        return 48 + int'(v & 16'h00FF) + int'((v >> 8) & 16'h007F);
    endfunction

    // reference LFSR history: hist[c] is the value held after edge c
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mlfsr <= Reset_n ? lfsr_step(mlfsr) : 16'hACE1;
        hist[cyc + 1] <= Reset_n ? lfsr_step(mlfsr) : 16'hACE1;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            mx[k] = 0;
            my[k] = 0;
        end
        mtot = 0;
    endtask

    task automatic model_load(input int l);
        for (int k = 0; k < 16; k++) begin
            my[k] = 465 - 30 * k;
            mx[k] = fx(hist[l + k]);
        end
        mtot = 0;
    endtask

    task automatic model_scroll(input logic [9:0] t, input int n);
        int tv;
        int mag;
        int ny;
        tv = int'(t);
        mag = 0;
        if (tv >= 512) begin
            mag = 1024 - tv;
            if (mag > 63) mag = 63;
        end
        mtot = (mtot + mag > 65535) ? 65535 : mtot + mag;
        for (int k = 0; k < 16; k++) begin
            ny = my[k] + mag;
            if (ny >= 480) begin
                my[k] = ny - 480;
                mx[k] = fx(hist[n + k]);
            end else begin
                my[k] = ny;
            end
        end
    endtask

    task automatic cmp_all(input string nm);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s x[%0d]", nm, k), int'(ox[k]), mx[k]);
            chk($sformatf("%s y[%0d]", nm, k), int'(oy[k]), my[k]);
        end
        chk({nm, " total"}, int'(scroll_total), mtot);
    endtask

    task automatic finish_load(input int l, input string nm);
        int cnt;
        cnt = 1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (busy) cnt++;
            else break;
        end
        chk({nm, " busy cycles"}, cnt, 16);
        chk({nm, " trigger"}, int'(trigger), 0);
        model_load(l);
        cmp_all(nm);
    endtask

    task automatic do_load(input string nm);
        int l;
        @(negedge clk);
        loadplat = 1'b1;
        @(posedge clk); #1;
        l = cyc;
        chk({nm, " busy start"}, int'(busy), 1);
        @(negedge clk);
        loadplat = 1'b0;
        finish_load(l, nm);
    endtask

    task automatic scroll(input logic [9:0] t, input bit drop,
                          input bit full, input string nm,
                          output int n0);
        int k;
        @(negedge clk);
        plat_temp_Y = t;
        refresh_en = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        n0 = cyc;
        chk({nm, " busy"}, int'(busy), 1);
        @(negedge clk);
        frame_tick = 1'b0;
        if (drop) begin
            repeat (3) @(negedge clk);
            refresh_en = 1'b0;
        end
        k = 0;
        while (trigger !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (cyc - n0 == 16) chk({nm, " busy end"}, int'(busy), 0);
        end
        chk({nm, " trig latency"}, cyc - n0, 17);
        if (drop) begin
            @(posedge clk); #1;
            chk({nm, " trig pulse"}, int'(trigger), 0);
        end else begin
            @(posedge clk); #1;
            chk({nm, " trig hold"}, int'(trigger), 1);
            @(negedge clk);
            refresh_en = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk({nm, " trig fall"}, int'(trigger), 0);
        end
        model_scroll(t, n0);
        if (full) cmp_all(nm);
    endtask

    typedef struct {
        logic [9:0] t;
        bit         drop;
        int         y0;
        int         y1;
        int         y15;
        int         tot;
        bit         x0_new;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int l;
        int px0;
        string nm;

        tbl[0] = '{10'h3F6, 1'b0, 475, 445, 25, 10, 1'b0};
        tbl[1] = '{10'h3F6, 1'b0, 5, 455, 35, 20, 1'b1};
        tbl[2] = '{10'h380, 1'b0, 68, 38, 98, 83, 1'b0};
        tbl[3] = '{10'h005, 1'b1, 68, 38, 98, 83, 1'b0};
        tbl[4] = '{10'h200, 1'b0, 131, 101, 161, 146, 1'b0};
        tbl[5] = '{10'h3FF, 1'b1, 132, 102, 162, 147, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cmp_all("reset");
        chk("reset busy", int'(busy), 0);
        chk("reset trigger", int'(trigger), 0);
        chk("sizeX", int'(sx), 16);
        chk("sizeY", int'(sy), 3);
        @(negedge clk);
        Reset_n = 1'b1;

        do_load("load");
        chk("load y0", int'(oy[0]), 465);
        chk("load y7", int'(oy[7]), 255);
        chk("load y15", int'(oy[15]), 15);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("load xrange[%0d]", k),
                int'(ox[k] >= 9'd48 && ox[k] <= 9'd430), 1);
        end

        for (int i = 0; i < 6; i++) begin
            nm = $sformatf("tbl%0d", i);
            px0 = int'(ox[0]);
            scroll(tbl[i].t, tbl[i].drop, 1'b1, nm, n0);
            chk({nm, " y0"}, int'(oy[0]), tbl[i].y0);
            chk({nm, " y1"}, int'(oy[1]), tbl[i].y1);
            chk({nm, " y15"}, int'(oy[15]), tbl[i].y15);
            chk({nm, " tot"}, int'(scroll_total), tbl[i].tot);
            if (tbl[i].x0_new) chk({nm, " x0"}, int'(ox[0]), fx(hist[n0]));
            else               chk({nm, " x0"}, int'(ox[0]), px0);
        end

        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 7) begin
                do_load($sformatf("rload%0d", i));
            end else begin
                scroll(10'($urandom_range(0, 1023)),
                       1'($urandom_range(0, 1)), 1'b1,
                       $sformatf("rnd%0d", i), n0);
            end
        end

        do_load("pre_int");
        @(negedge clk);
        plat_temp_Y = 10'h3EC;
        refresh_en = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (8) @(negedge clk);
        loadplat = 1'b1;
        refresh_en = 1'b0;
        @(posedge clk); #1;
        l = cyc;
        chk("int trigger", int'(trigger), 0);
        chk("int busy", int'(busy), 1);
        @(negedge clk);
        loadplat = 1'b0;
        finish_load(l, "int");

        @(negedge clk);
        plat_temp_Y = 10'h3F6;
        refresh_en = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        Reset_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        cmp_all("rst_mid");
        chk("rst_mid busy", int'(busy), 0);
        chk("rst_mid trigger", int'(trigger), 0);
        @(negedge clk);
        refresh_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        refresh_en = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        chk("idle busy", int'(busy), 0);
        @(negedge clk);
        refresh_en = 1'b0;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        chk("idle trigger", int'(trigger), 0);
        cmp_all("idle hold");

        do_load("sat_load");
        for (int i = 0; i < 1045; i++) begin
            scroll(10'h3C1, 1'b0, 1'b0, "sat", n0);
        end
        chk("sat total", int'(scroll_total), 65535);
        cmp_all("sat");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
